// File: rtl/bist_pattern_ctrl.sv
// BIST controller: drives test vectors into a 4-in/2-out CUT and compacts responses in a MISR.
// Optional macro BIST_LFSR_EN selects a 4-bit LFSR pattern source instead of a binary count.
module bist_pattern_ctrl #(
   parameter int                NVEC   = 16,
   parameter int                SETTLE = 1,
   parameter int                SIG_W  = 8,
   parameter logic [SIG_W-1:0]  POLY   = 8'h1D,
   parameter logic [SIG_W-1:0]  GOLDEN = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [3:0]       cut_in,
   input  logic [1:0]       cut_resp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [SIG_W-1:0] signature,
   output logic [3:0]       vec_idx
);

   localparam int              SCW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE - 1);
   localparam logic [3:0]      LAST_IDX    = 4'(NVEC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_CAPTURE,
      S_CHECK
   } stateT;

   stateT             r_state;
   stateT             w_stateNext;
   logic [SCW-1:0]    r_settleCnt;
   logic [3:0]        r_vecIdx;
   logic [3:0]        r_cutIn;
   logic [SIG_W-1:0]  r_misr;
   logic              r_pass;

   logic              w_settleDone;
   logic              w_lastVec;
   logic [SIG_W-1:0]  w_misrNext;
   logic [3:0]        w_firstPat;
   logic [3:0]        w_nextPat;

   assign w_settleDone = (r_settleCnt == SETTLE_LAST);
   assign w_lastVec    = (r_vecIdx == LAST_IDX);

   // Old MSB is shifted out before the polynomial is folded back in.
   assign w_misrNext = {r_misr[SIG_W-2:0], 1'b0}
                     ^ (r_misr[SIG_W-1] ? POLY : {SIG_W{1'b0}})
                     ^ {{(SIG_W-2){1'b0}}, cut_resp};

`ifdef BIST_LFSR_EN
   // The applied vector doubles as the LFSR state; slot 14 is followed by the all-zero code.
   assign w_firstPat = 4'b0001;
   assign w_nextPat  = (r_vecIdx == 4'd14) ? 4'd0
                                           : {r_cutIn[2:0], r_cutIn[3] ^ r_cutIn[2]};
`else
   assign w_firstPat = 4'b0000;
   assign w_nextPat  = r_vecIdx + 4'd1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:    if (start) w_stateNext = S_APPLY;
         S_APPLY:   if (w_settleDone) w_stateNext = S_CAPTURE;
         S_CAPTURE: w_stateNext = w_lastVec ? S_CHECK : S_APPLY;
         S_CHECK:   w_stateNext = S_IDLE;
         default:   w_stateNext = S_IDLE;
      endcase
   end

   // Pass is resolved on the final capture edge so it is already valid in the CHECK cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_settleCnt <= '0;
         r_vecIdx    <= '0;
         r_cutIn     <= '0;
         r_misr      <= '0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_settleCnt <= '0;
               if (start) begin
                  r_misr   <= '0;
                  r_vecIdx <= '0;
                  r_pass   <= 1'b0;
                  r_cutIn  <= w_firstPat;
               end
            end
            S_APPLY: begin
               r_settleCnt <= w_settleDone ? '0 : r_settleCnt + 1'b1;
            end
            S_CAPTURE: begin
               r_misr <= w_misrNext;
               if (w_lastVec) begin
                  r_pass <= (w_misrNext == GOLDEN);
               end else begin
                  r_vecIdx <= r_vecIdx + 4'd1;
                  r_cutIn  <= w_nextPat;
               end
            end
            default: begin
               r_settleCnt <= '0;
            end
         endcase
      end
   end

   assign cut_in    = r_cutIn;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_CHECK);
   assign pass      = r_pass;
   assign signature = r_misr;
   assign vec_idx   = r_vecIdx;

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Self-checking bench for bist_pattern_ctrl: random CUT responses scored against a run-level model.
// Honours BIST_LFSR_EN for the expected pattern sequence.
module tb_bist_pattern_ctrl;

   localparam int          NVEC   = 16;
   localparam int          SETTLE = 1;
   localparam int          SIG_W  = 8;
   localparam logic [7:0]  POLY   = 8'h1D;
   localparam logic [7:0]  GOLDEN = 8'h00;
   localparam int          VCYC   = SETTLE + 1;
   localparam int          RUNLEN = NVEC * VCYC;

   logic             clk;
   logic             rst;
   logic             start;
   logic [3:0]       cut_in;
   logic [1:0]       cut_resp;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;
   logic [3:0]       vec_idx;

   int numChecks = 0;
   int numFails  = 0;
   int lastSig   = 0;

   bist_pattern_ctrl #(
      .NVEC   (NVEC),
      .SETTLE (SETTLE),
      .SIG_W  (SIG_W),
      .POLY   (POLY),
      .GOLDEN (GOLDEN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cut_in    (cut_in),
      .cut_resp  (cut_resp),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .signature (signature),
      .vec_idx   (vec_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector for slot i, derived directly from the pattern rules.
   function automatic int patternOf(input int i);
`ifdef BIST_LFSR_EN
      int s;
      s = 1;
      if (i == 15) return 0;
      for (int j = 0; j < i; j++) s = ((s * 2) & 15) | (((s >> 3) ^ (s >> 2)) & 1);
      return s;
`else
      return i;
`endif
   endfunction

   // One signature-register step on integers: double, fold polynomial on overflow, add response.
   function automatic int misrStep(input int m, input int r);
      int n;
      n = (m * 2) % (1 << SIG_W);
      if (m >= (1 << (SIG_W - 1))) n = n ^ int'(POLY);
      return n ^ r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // One complete run. respMode: 0 = tie 00, 1 = tie 01, 2 = random.
   // kickStart pulses start mid-run; chainStart holds start high from CHECK into IDLE.
   task automatic applyStimulus(input int respMode, input bit kickStart, input bit chainStart);
      int model;
      int idx;
      int kick;
      int r;
      bit isCapture;
      model = 0;
      kick  = kickStart ? int'($urandom_range(RUNLEN, 2)) : -1;
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= RUNLEN + 1; c++) begin
         @(negedge clk);
         idx = (c - 1) / VCYC;
         if (idx > NVEC - 1) idx = NVEC - 1;
         checkOutput("busy",    32'(busy),      32'd1);
         checkOutput("done",    32'(done),      32'(c == RUNLEN + 1));
         checkOutput("vec_idx", 32'(vec_idx),   32'(idx));
         checkOutput("cut_in",  32'(cut_in),    32'(patternOf(idx)));
         checkOutput("sig_run", 32'(signature), 32'(model));
         if (c == RUNLEN + 1) checkOutput("pass_done", 32'(pass), 32'(model == int'(GOLDEN)));
         else                 checkOutput("pass_run",  32'(pass), 32'd0);
         start = (c == kick) || (chainStart && c == RUNLEN + 1);
         case (respMode)
            0:       r = 0;
            1:       r = 1;
            default: r = int'($urandom_range(3, 0));
         endcase
         cut_resp  = 2'(r);
         isCapture = (c <= RUNLEN) && (((c - 1) % VCYC) == SETTLE);
         if (isCapture) model = misrStep(model, r);
      end
      @(negedge clk);
      checkOutput("busy_idle", 32'(busy),      32'd0);
      checkOutput("done_idle", 32'(done),      32'd0);
      checkOutput("sig_hold",  32'(signature), 32'(model));
      checkOutput("pass_hold", 32'(pass),      32'(model == int'(GOLDEN)));
      start   = chainStart;
      lastSig = model;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_cut_in"},  32'(cut_in),    32'd0);
      checkOutput({tag, "_busy"},    32'(busy),      32'd0);
      checkOutput({tag, "_done"},    32'(done),      32'd0);
      checkOutput({tag, "_pass"},    32'(pass),      32'd0);
      checkOutput({tag, "_sig"},     32'(signature), 32'd0);
      checkOutput({tag, "_vec_idx"}, 32'(vec_idx),   32'd0);
   endtask

   // Starts a run, asserts reset after atCycle cycles, and confirms no done pulse follows.
   task automatic applyResetMidRun(input int atCycle);
      int doneSeen;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      cut_resp = 2'(int'($urandom_range(3, 0)));
      repeat (atCycle - 1) @(negedge clk);
      checkOutput("busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      checkAllZero("midrst");
      @(negedge clk);
      rst      = 1'b0;
      doneSeen = 0;
      repeat (RUNLEN + 8) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("no_done_after_rst", 32'(doneSeen), 32'd0);
      checkOutput("idle_after_rst",    32'(busy),     32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      cut_resp = 2'b00;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b0;
      @(negedge clk);
      checkAllZero("post_reset");

      $display("[TB] run with response tied to 00");
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput("sig_resp00",  32'(signature), 32'h00);
      checkOutput("pass_resp00", 32'(pass),      32'd1);

      $display("[TB] run with response tied to 01");
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput("sig_resp01",  32'(signature), 32'h3B);
      checkOutput("pass_resp01", 32'(pass),      32'd0);

      $display("[TB] random-response runs with stray start pulses");
      for (int n = 0; n < 6; n++) begin
         applyStimulus(2, 1'b1, (n % 2) == 1);
         if ((n % 2) == 0) begin
            repeat (int'($urandom_range(3, 0))) begin
               @(negedge clk);
               checkOutput("idle_gap_busy", 32'(busy),      32'd0);
               checkOutput("idle_gap_sig",  32'(signature), 32'(lastSig));
            end
         end
      end

      $display("[TB] reset asserted mid-run");
      applyResetMidRun(12);
      applyStimulus(1, 1'b0, 1'b0);
      checkOutput("sig_after_rst", 32'(signature), 32'h3B);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
